// File: rtl/vga_pkg.sv
// Shared VGA definitions for the disparity display path: 640x480@60 timing,
// stored disparity image size, RGB444 pixel type and bank-swap FSM states.
// Latency: n/a (declarations only). Backpressure: n/a.
package vga_pkg;

  // Horizontal timing in pixels: visible / front porch / sync / back porch / total
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;

  // Vertical timing in lines: visible / front porch / sync / back porch / total
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = 525;

  // Stored disparity image size (upscaled to the visible area on display)
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } swap_state_t;

endpackage

// File: rtl/disp_colormap.sv
// Maps one disparity sample to an RGB444 pixel from its top 4 bits.
// Latency: combinational. Backpressure: none.
// Build option: DISP_COLORMAP_EN selects a pseudo-colour ramp; otherwise grayscale.
// Ports: disp (disparity sample in), rgb (pixel colour out).
module disp_colormap
  import vga_pkg::*;
#(
  parameter int DISP_W = 6
) (
  input  logic [DISP_W-1:0] disp,
  output rgb444_t           rgb
);

  logic [3:0] d4;
  logic       unused_lsbs;

  assign d4 = disp[DISP_W-1 -: 4];
  // Sub-4-bit precision is dropped on purpose; keep the reduction so the
  // discarded bits are visibly consumed.
  assign unused_lsbs = ^disp;

`ifdef DISP_COLORMAP_EN
  // red ramps up, blue ramps down, green is a tent peaking at mid-scale.
  always_comb begin
    rgb.r = d4;
    rgb.b = 4'd15 - d4;
    if (!d4[3]) begin
      rgb.g = {d4[2:0], 1'b0};        // 2*d4
    end else begin
      rgb.g = {~d4[2:0], 1'b1};       // 2*(15-d4)+1, since 15-d4 == ~d4[2:0] here
    end
  end
`else
  always_comb begin
    rgb.r = d4;
    rgb.g = d4;
    rgb.b = d4;
  end
`endif

endmodule

// File: rtl/disp_vga_fetch.sv
// Fetches the 2x-upscaled disparity frame for the VGA scan and emits RGB444
// with sync/DE re-aligned; owns the tear-free frame-boundary bank swap.
// Latency: one pixel period (4 clk) from timing inputs to outputs. Backpressure: none.
// Build option: DISP_COLORMAP_EN (pseudo-colour map in disp_colormap).
// Ports: clk/reset; pclk, h_sync_in, v_sync_in, de_in, x_pixel, y_pixel from the
// timing generator; rd_en/rd_addr/rd_bank/rd_data to the frame buffer;
// swap_req/swap_ack with the stereo core; red/green/blue, h_sync, v_sync, DE out.
module disp_vga_fetch
  import vga_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int SCALE_SHIFT = 1,
  parameter int DISP_W      = 6,
  parameter int ADDR_W      = 17,
  parameter int MEM_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pclk,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              de_in,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  input  logic [DISP_W-1:0] rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              h_sync,
  output logic              v_sync,
  output logic              DE
);

  if (MEM_LAT < 1 || MEM_LAT > 3 || DISP_W < 4 ||
      (64'd1 << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_bad_params
    $error("disp_vga_fetch: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Stage 1: address generation and timing shadows
  // ---------------------------------------------------------------------------
  logic [9:0]  src_x;
  logic [9:0]  src_y;
  logic [31:0] addr_full;
  logic        hs1;
  logic        vs1;
  logic        de1;

  assign src_x     = x_pixel >> SCALE_SHIFT;
  assign src_y     = y_pixel >> SCALE_SHIFT;
  // Out-of-range source coordinates simply wrap via truncation.
  assign addr_full = 32'(src_y) * unsigned'(IMG_W) + 32'(src_x);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      de1     <= 1'b0;
    end else begin
      // Strobe lives for exactly the clk following the pclk cycle.
      rd_en <= pclk & de_in;
      if (pclk) begin
        if (de_in) begin
          rd_addr <= addr_full[ADDR_W-1:0];
        end
        hs1 <= h_sync_in;
        vs1 <= v_sync_in;
        de1 <= de_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour map and aligned outputs. rd_data has had 3 clk since the
  // strobe, which covers the whole legal memory latency range.
  // ---------------------------------------------------------------------------
  rgb444_t cmap;

  disp_colormap #(
    .DISP_W (DISP_W)
  ) u_colormap (
    .disp (rd_data),
    .rgb  (cmap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      red    <= 4'h0;
      green  <= 4'h0;
      blue   <= 4'h0;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
      DE     <= 1'b0;
    end else if (pclk) begin
      h_sync <= hs1;
      v_sync <= vs1;
      DE     <= de1;
      if (de1) begin
        red   <= cmap.r;
        green <= cmap.g;
        blue  <= cmap.b;
      end else begin
        red   <= 4'h0;
        green <= 4'h0;
        blue  <= 4'h0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank swap FSM: a request waits for the start of vsync so a displayed
  // frame is never mixed across banks.
  // ---------------------------------------------------------------------------
  swap_state_t state;
  swap_state_t state_nxt;
  logic        frame_boundary;

  // Falling edge of vsync as seen on pixel-enable cycles. The DE terms are
  // already 0 there in standard timing; they make the no-swap-while-visible
  // guarantee independent of the generator's porch settings.
  assign frame_boundary = pclk & ~v_sync_in & vs1 & ~de_in & ~de1 & ~DE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SHOW;
      rd_bank  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      swap_ack <= (state == SWAP);
      if (state == SWAP) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SHOW:    if (swap_req) state_nxt = PENDING;
      // Further requests while pending collapse into the one swap.
      PENDING: if (frame_boundary) state_nxt = SWAP;
      SWAP:    state_nxt = SHOW;
      default: state_nxt = SHOW;
    endcase
  end

endmodule

// File: tb/tb_disp_vga_fetch.sv
module tb_disp_vga_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pclk = 1'b0;
  logic        h_sync_in = 1'b1;
  logic        v_sync_in = 1'b1;
  logic        de_in = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [9:0]  y_pixel = '0;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic        rd_bank;
  logic [5:0]  rd_data;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [3:0]  red, green, blue;
  logic        h_sync, v_sync, DE;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  disp_vga_fetch dut (
    .clk(clk), .reset(reset), .pclk(pclk),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_data(rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .red(red), .green(green), .blue(blue),
    .h_sync(h_sync), .v_sync(v_sync), .DE(DE)
  );

  always #5 clk = ~clk;

  // One-clk pixel enable every 4 clk, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk); pclk = 1'b1;
      @(negedge clk); pclk = 1'b0;
      repeat (2) @(negedge clk);
    end
  end

  // Frame buffer model with a read latency of 2 clk; returns mem_word.
  logic [5:0] mem_word = '0;
  logic [5:0] p0 = '0;
  logic [5:0] p1 = '0;
  always @(posedge clk) begin
    if (rd_en) p0 <= mem_word;
    p1 <= p0;
  end
  assign rd_data = p1;

  always @(negedge clk) if (swap_ack === 1'b1) ack_cnt++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Advance to the next pclk clock edge, then 1 ns past it.
  task automatic next_pclk();
    int n = 0;
    @(posedge clk);
    while (pclk !== 1'b1 && n < 8) begin
      @(posedge clk);
      n++;
    end
    if (n >= 8) begin
      checks++;
      failures++;
      $display("FAIL pclk_wait actual=timeout required=pulse");
    end
    #1;
  endtask

  task automatic drive(input logic de, input logic [9:0] x, input logic [9:0] y,
                       input logic hs, input logic vs);
    de_in = de; x_pixel = x; y_pixel = y; h_sync_in = hs; v_sync_in = vs;
  endtask

  task automatic pulse_req();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  typedef struct {
    logic        de;
    logic [9:0]  x, y;
    logic        hs, vs;
    logic [5:0]  dat;
    logic [16:0] exp_addr;
    logic [3:0]  er, eg, eb;
  } vec_t;

  function automatic vec_t mk(logic de, logic [9:0] x, logic [9:0] y, logic hs, logic vs,
                              logic [5:0] dat, logic [16:0] ea,
                              logic [3:0] er, logic [3:0] eg, logic [3:0] eb);
    vec_t v;
    v.de = de; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.dat = dat;
    v.exp_addr = ea; v.er = er; v.eg = eg; v.eb = eb;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
`ifdef DISP_COLORMAP_EN
    vecs[0] = mk(1, 5,   3,   1, 1, 6'b101100, 17'd322,   4'd11, 4'd9,  4'd4);
    vecs[1] = mk(1, 639, 479, 1, 1, 6'h3F,     17'd76799, 4'd15, 4'd1,  4'd0);
    vecs[3] = mk(1, 0,   0,   1, 1, 6'h00,     17'd0,     4'd0,  4'd0,  4'd15);
    vecs[4] = mk(1, 2,   1,   1, 1, 6'b100000, 17'd1,     4'd8,  4'd15, 4'd7);
    vecs[6] = mk(1, 320, 240, 1, 1, 6'b110101, 17'd38560, 4'd13, 4'd5,  4'd2);
`else
    vecs[0] = mk(1, 5,   3,   1, 1, 6'b101100, 17'd322,   4'd11, 4'd11, 4'd11);
    vecs[1] = mk(1, 639, 479, 1, 1, 6'h3F,     17'd76799, 4'd15, 4'd15, 4'd15);
    vecs[3] = mk(1, 0,   0,   1, 1, 6'h00,     17'd0,     4'd0,  4'd0,  4'd0);
    vecs[4] = mk(1, 2,   1,   1, 1, 6'b100000, 17'd1,     4'd8,  4'd8,  4'd8);
    vecs[6] = mk(1, 320, 240, 1, 1, 6'b110101, 17'd38560, 4'd13, 4'd13, 4'd13);
`endif
    // Blanking: address holds, colour forced to zero regardless of rd_data.
    vecs[2] = mk(0, 100, 50,  0, 1, 6'h3F, 17'd76799, 4'd0, 4'd0, 4'd0);
    vecs[5] = mk(0, 656, 490, 0, 0, 6'h2A, 17'd1,     4'd0, 4'd0, 4'd0);

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_red", red, 0);   chk("rst_green", green, 0); chk("rst_blue", blue, 0);
    chk("rst_de", DE, 0);     chk("rst_hsync", h_sync, 1); chk("rst_vsync", v_sync, 1);
    chk("rst_rd_en", rd_en, 0); chk("rst_rd_addr", rd_addr, 0);
    chk("rst_bank", rd_bank, 0); chk("rst_ack", swap_ack, 0);
    reset = 1'b0;
    next_pclk();

    // ---------------- table vectors ----------------
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs);
      mem_word = vecs[i].dat;
      next_pclk();
      chk($sformatf("v%0d_rd_en", i), rd_en, vecs[i].de);
      chk($sformatf("v%0d_rd_addr", i), rd_addr, vecs[i].exp_addr);
      drive(0, 0, 0, 1, 1);
      next_pclk();
      chk($sformatf("v%0d_idle_rd_en", i), rd_en, 0);
      chk($sformatf("v%0d_red", i), red, vecs[i].er);
      chk($sformatf("v%0d_green", i), green, vecs[i].eg);
      chk($sformatf("v%0d_blue", i), blue, vecs[i].eb);
      chk($sformatf("v%0d_de", i), DE, vecs[i].de);
      chk($sformatf("v%0d_hsync", i), h_sync, vecs[i].hs);
      chk($sformatf("v%0d_vsync", i), v_sync, vecs[i].vs);
    end

    // ---------------- latency / alignment: exactly 4 clk ----------------
    drive(1, 5, 3, 0, 0);
    mem_word = 6'b101100;
    next_pclk();
    drive(0, 0, 0, 1, 1);
    chk("lat_rd_en_k", rd_en, 1);
    tick();
    chk("lat_rd_en_pulse_width", rd_en, 0);
    tick(); tick();
    chk("lat_hsync_k3", h_sync, 1); chk("lat_vsync_k3", v_sync, 1); chk("lat_de_k3", DE, 0);
    tick();
    chk("lat_hsync_k4", h_sync, 0); chk("lat_vsync_k4", v_sync, 0);
    chk("lat_de_k4", DE, 1);        chk("lat_red_k4", red, 4'hB);
    next_pclk();

    // ---------------- swap timing with coalesced requests ----------------
    ack_cnt = 0;
    drive(1, 0, 100, 1, 1);
    next_pclk();
    pulse_req();
    drive(1, 0, 200, 1, 1);
    repeat (3) next_pclk();
    chk("swap_bank_mid_frame", rd_bank, 0);
    chk("swap_acks_mid_frame", ack_cnt, 0);
    pulse_req();
    drive(0, 0, 480, 1, 1);
    repeat (3) next_pclk();
    chk("swap_bank_pre_vsync", rd_bank, 0);
    drive(0, 0, 490, 1, 0);
    next_pclk();
    chk("swap_bank_at_boundary", rd_bank, 0);
    tick();
    chk("swap_bank_toggled", rd_bank, 1);
    chk("swap_ack_high", swap_ack, 1);
    tick();
    chk("swap_ack_one_clk", swap_ack, 0);
    drive(0, 0, 491, 1, 0);
    repeat (2) next_pclk();
    drive(0, 0, 492, 1, 1);
    repeat (2) next_pclk();
    chk("swap_single_ack", ack_cnt, 1);
    chk("swap_bank_held", rd_bank, 1);

    // ---------------- mid-frame reset ----------------
    pulse_req();
    drive(1, 10, 20, 1, 1);
    mem_word = 6'h3F;
    repeat (2) next_pclk();
    chk("mrst_pre_de", DE, 1);
    chk("mrst_pre_red", red, 4'hF);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_red", red, 0); chk("mrst_green", green, 0); chk("mrst_blue", blue, 0);
    chk("mrst_de", DE, 0);   chk("mrst_hsync", h_sync, 1); chk("mrst_vsync", v_sync, 1);
    chk("mrst_bank", rd_bank, 0); chk("mrst_rd_addr", rd_addr, 0);
    // Pending request must be gone: a boundary now produces no swap.
    drive(0, 0, 489, 1, 1);
    next_pclk();
    drive(0, 0, 490, 1, 0);
    next_pclk();
    repeat (3) tick();
    chk("mrst_no_swap_acks", ack_cnt, 1);
    chk("mrst_no_swap_bank", rd_bank, 0);
    drive(0, 0, 1, 1, 1);
    next_pclk();
    drive(1, 5, 3, 1, 1);
    mem_word = 6'b101100;
    next_pclk();
    chk("mrst_resume_addr", rd_addr, 322);
    drive(0, 0, 1, 1, 1);
    next_pclk();
    chk("mrst_resume_red", red, 4'hB);
    chk("mrst_resume_de", DE, 1);

    // ---------------- request coincident with a frame boundary ----------------
    drive(0, 0, 489, 1, 1);
    next_pclk();
    repeat (3) tick();
    swap_req = 1'b1;
    drive(0, 0, 490, 1, 0);
    next_pclk();
    swap_req = 1'b0;
    repeat (3) tick();
    chk("coinc_no_ack_now", ack_cnt, 1);
    chk("coinc_bank_now", rd_bank, 0);
    drive(0, 0, 491, 1, 0);
    next_pclk();
    drive(0, 0, 1, 1, 1);
    repeat (2) next_pclk();
    drive(0, 0, 490, 1, 0);
    next_pclk();
    repeat (2) tick();
    chk("coinc_next_frame_ack", ack_cnt, 2);
    chk("coinc_next_frame_bank", rd_bank, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
